// File: rtl/debouncer_bank.sv
// debouncer_bank: N independent button debouncers with press/release pulses.
// Each channel runs a two-flop synchroniser, a stability counter and a
// four-state FSM. A level change is accepted after MAX consecutive samples
// that differ from the debounced level.
// Optional auto-repeat is compiled in with `define DEBOUNCER_BANK_REPEAT_EN.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RELEASED     | debounced level 0, synchronised input agrees
// PRESS_WAIT   | level 0, counting consecutive high samples
// PRESSED      | debounced level 1, synchronised input agrees (repeat runs)
// RELEASE_WAIT | level 1, counting consecutive low samples
module debouncer_bank #(
  parameter int N             = 4,
  parameter int MAX           = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] button_in,
  output logic [N-1:0] button_level,
  output logic [N-1:0] button_press,
  output logic [N-1:0] button_release,
  output logic         any_press
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int CW = $clog2(MAX + 1);
  // Last count value before acceptance: the edge that would make the count
  // reach MAX is the edge that toggles the level instead.
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX - 1);

`ifdef DEBOUNCER_BANK_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  // Down-counter reload values; a pulse fires on the edge the timer is zero.
  localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);
`endif

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic          sync1;
    logic          sync2;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
`ifdef DEBOUNCER_BANK_REPEAT_EN
    logic [RW-1:0] rpt_tmr;
`endif

    // Two-flop synchroniser for the raw asynchronous button level.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= button_in[g];
        sync2 <= sync1;
      end
    end

    // Debounce FSM: count differing samples, accept at MAX, pulse one cycle.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state     <= RELEASED;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
`ifdef DEBOUNCER_BANK_REPEAT_EN
        rpt_tmr   <= '0;
`endif
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          RELEASED, PRESS_WAIT: begin
            if (sync2) begin
              if (cnt == CNT_LAST) begin
                state   <= PRESSED;
                cnt     <= '0;
                level_q <= 1'b1;
                press_q <= 1'b1;
`ifdef DEBOUNCER_BANK_REPEAT_EN
                rpt_tmr <= RPT_FIRST;
`endif
              end else begin
                state <= PRESS_WAIT;
                cnt   <= cnt + 1'b1;
              end
            end else begin
              state <= RELEASED;
              cnt   <= '0;
            end
          end
          PRESSED, RELEASE_WAIT: begin
`ifdef DEBOUNCER_BANK_REPEAT_EN
            rpt_tmr <= '0;
`endif
            if (!sync2) begin
              if (cnt == CNT_LAST) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                release_q <= 1'b1;
              end else begin
                state <= RELEASE_WAIT;
                cnt   <= cnt + 1'b1;
              end
            end else begin
              state <= PRESSED;
              cnt   <= '0;
`ifdef DEBOUNCER_BANK_REPEAT_EN
              // A release glitch restarts the repeat cadence at the period.
              if (state == RELEASE_WAIT) begin
                rpt_tmr <= RPT_NEXT;
              end else if (rpt_tmr == '0) begin
                press_q <= 1'b1;
                rpt_tmr <= RPT_NEXT;
              end else begin
                rpt_tmr <= rpt_tmr - 1'b1;
              end
`endif
            end
          end
          default: begin
            state <= RELEASED;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign button_level[g]   = level_q;
    assign button_press[g]   = press_q;
    assign button_release[g] = release_q;
  end

  // Same-cycle summary of every channel's press pulse.
  assign any_press = |button_press;

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank with N=2, MAX=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Repeat expectations follow DEBOUNCER_BANK_REPEAT_EN.
module tb_debouncer_bank;

  localparam int N = 2;

  logic         clock;
  logic         reset;
  logic [N-1:0] button_in;
  logic [N-1:0] button_level;
  logic [N-1:0] button_press;
  logic [N-1:0] button_release;
  logic         any_press;

  int total;
  int bad;

  debouncer_bank #(
    .N(N), .MAX(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clock(clock),
    .reset(reset),
    .button_in(button_in),
    .button_level(button_level),
    .button_press(button_press),
    .button_release(button_release),
    .any_press(any_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle; edge e of a scenario is the e-th call
  // after the stimulus change.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    reset = 1'b0;
    button_in = 2'b11;
    for (int e = 0; e < 4; e++) begin
      tick();
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("FAIL reset_hold e=%0d got=%b want=%b", e, obs, 7'b0);
      end
    end
    button_in = 2'b00;
    reset = 1'b1;
    for (int e = 0; e < 6; e++) begin
      tick();
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("FAIL reset_idle e=%0d got=%b want=%b", e, obs, 7'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [6:0] obs, exp;
    button_in = 2'b01;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00, (e == 5)};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL clean_press e=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [6:0] obs, exp;
    button_in = 2'b00;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b00 : 2'b01, 2'b00, (e == 5) ? 2'b01 : 2'b00, 1'b0};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL release e=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  // Three high samples (count reaches MAX-1), one low, then steady high.
  task automatic test_bounce();
    logic [6:0] obs, exp;
    logic [N-1:0] pattern [4];
    pattern = '{2'b01, 2'b01, 2'b01, 2'b00};
    for (int e = 0; e < 4; e++) begin
      button_in = pattern[e];
      tick();
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("FAIL bounce_quiet e=%0d got=%b want=%b", e, obs, 7'b0);
      end
    end
    button_in = 2'b01;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b01 : 2'b00, (e == 5) ? 2'b01 : 2'b00, 2'b00, (e == 5)};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL bounce_press e=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] obs, exp;
    button_in = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b11 : 2'b00, (e == 5) ? 2'b11 : 2'b00, 2'b00, (e == 5)};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL simul_press e=%0d got=%b want=%b", e, obs, exp);
      end
    end
    button_in = 2'b00;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b00 : 2'b11, 2'b00, (e == 5) ? 2'b11 : 2'b00, 1'b0};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL simul_release e=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  // Hold ch0 through edge 24 (a repeat edge), so the two still-PRESSED edges
  // after the input drops do not reach the next repeat.
  task automatic test_repeat();
    logic [6:0] obs, exp;
    logic       rp;
    button_in = 2'b01;
    for (int e = 0; e < 25; e++) begin
      tick();
`ifdef DEBOUNCER_BANK_REPEAT_EN
      rp = (e == 5) || (e == 15) || (e == 18) || (e == 21) || (e == 24);
`else
      rp = (e == 5);
`endif
      exp = {(e >= 5) ? 2'b01 : 2'b00, {1'b0, rp}, 2'b00, rp};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL repeat_hold e=%0d got=%b want=%b", e, obs, exp);
      end
    end
    button_in = 2'b00;
    for (int e = 0; e < 14; e++) begin
      tick();
      exp = {(e >= 5) ? 2'b00 : 2'b01, 2'b00, (e == 5) ? 2'b01 : 2'b00, 1'b0};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL repeat_stop e=%0d got=%b want=%b", e, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] obs, exp;
    button_in = 2'b01;
    for (int e = 0; e < 3; e++) begin
      tick();
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("FAIL midcount_pre e=%0d got=%b want=%b", e, obs, 7'b0);
      end
    end
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    // Input held through reset release: press expected at edge MAX+2 = 6.
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = {(e >= 6) ? 2'b01 : 2'b00, (e == 6) ? 2'b01 : 2'b00, 2'b00, (e == 6)};
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_held e=%0d got=%b want=%b", e, obs, exp);
      end
    end
    // Reset while pressed clears the level asynchronously and emits nothing.
    #2 reset = 1'b0;
    #1;
    obs = {button_level, button_press, button_release, any_press};
    total++;
    if (obs !== 7'b0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", obs, 7'b0);
    end
    button_in = 2'b00;
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      obs = {button_level, button_press, button_release, any_press};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("FAIL reset_after e=%0d got=%b want=%b", e, obs, 7'b0);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    button_in = '0;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_simultaneous();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debouncer_bank.md
DEBOUNCER_BANK -- requirements
Module: debouncer_bank

Interface
REQ-001 Parameters SHALL be:
- N, default 4: number of independent button channels (1..32).
- MAX, default 50000: consecutive stable clock samples required to accept a level change (>=1).
- REPEAT_DELAY, default 25000000: cycles from accepted press to first auto-repeat pulse (>=1).
- REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses (>=1).
REQ-002 Ports SHALL be (clock and reset first):
- clock  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- button_in  input  N  raw, asynchronous, bouncing button levels.
- button_level  output  N  debounced stable level per channel.
- button_press  output  N  one-cycle pulse per accepted press (and per repeat when enabled).
- button_release  output  N  one-cycle pulse per accepted release.
- any_press  output  1  OR-reduction of button_press.

Function
REQ-003 Each channel SHALL pass button_in through a two-flop synchroniser before any other logic.
REQ-004 Each channel SHALL have a counter of width $clog2(MAX+1) that increments on every edge where the synchronised input differs from button_level, and clears on any edge where they are equal.
REQ-005 When a channel's differing-sample count reaches MAX, at that edge button_level SHALL toggle, the counter SHALL clear, and button_press (0->1) or button_release (1->0) SHALL assert for exactly one cycle.
REQ-006 Latency: raw change set up before edge k and held stable SHALL produce the level and pulse at edge k+1+MAX.
REQ-007 A single opposite sample before the count reaches MAX SHALL restart the count from zero; no partial credit is kept.
REQ-008 Channel state SHALL be per-channel FSM: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; xxx_WAIT entered on first differing sample, exited to the new level on count==MAX or back on any agreeing sample.
REQ-009 Channels SHALL be fully independent; simultaneous events on several channels SHALL yield simultaneous pulses in the same cycle.
REQ-010 button_press and button_release SHALL never assert together on one channel.
REQ-011 any_press SHALL be combinational OR of button_press (same cycle).
REQ-012 Counter SHALL never wrap; it is bounded by clearing at MAX.

Reset
REQ-013 reset low SHALL asynchronously clear synchronisers, counters, repeat timers, FSMs to RELEASED, and all outputs to 0.
REQ-014 A button held high through reset release SHALL be treated as a new press: press pulse after MAX+2 edges.
REQ-015 Reset asserted mid-count or mid-repeat SHALL discard all progress with no pulse emitted.

Configuration
REQ-016 Macro DEBOUNCER_BANK_REPEAT_EN SHALL compile in auto-repeat.
REQ-017 With the macro, while a channel stays PRESSED, a repeat timer SHALL emit button_press REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles; timer clears on leaving PRESSED.
REQ-018 Without the macro, no repeat timer logic SHALL exist; exactly one press pulse per accepted press.

Verification (N=2, MAX=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-019 Clean press: ch0 0->1 before edge 0, held -> button_level[0]=1 and one-cycle button_press[0]/any_press at edge 5; ch1 stays 0.
REQ-020 Bounce: ch0 high 3 cycles, low 1, then high -> no pulse during bounce; press at edge 5 after final rise.
REQ-021 Release: held ch0 driven low -> button_release[0] one cycle, level 0 after MAX+1 edges; no press pulse.
REQ-022 Simultaneous: both channels rise together -> button_press=2'b11 in the same cycle.
REQ-023 Repeat (macro on): hold ch0 -> presses at edges 5, 15, 18, 21...; release stops them; macro off -> only edge 5.
REQ-024 Reset mid-count: reset low at edge 2 of a press -> outputs 0, no pulse; input held after release -> press at MAX+2 edges.
